// File: rtl/vga_timing_pkg.sv
// Shared raster timing defaults (640x480@60), coordinate type and decode helpers
// for the vga_timing_gen slice.
package vga_timing_pkg;

  localparam int DEF_H_VISIBLE  = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_H_TOTAL    = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_VISIBLE  = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_V_TOTAL    = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  localparam int DEF_SYNC_DELAY = 1;
  localparam int COORD_W        = 10;
  localparam int MAX_TOTAL      = 1 << COORD_W;
  localparam int MAX_SYNC_DELAY = 4;

  typedef logic [COORD_W-1:0] coord_t;

  // Per-pixel decode, registered alongside the counters so it lines up with DrawX/DrawY.
  typedef struct packed {
    logic blank;
    logic line_start;
    logic frame_start;
    logic hs_raw;
    logic vs_raw;
  } raster_flags_t;

  localparam raster_flags_t FLAGS_RESET = '{
    blank:       1'b1,
    line_start:  1'b1,
    frame_start: 1'b1,
    hs_raw:      1'b1,
    vs_raw:      1'b1
  };

  // Half-open window test; int bounds so an end value of 1024 is still representable.
  function automatic logic in_window(input coord_t v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Parameterised-depth shift register for the sync outputs; every stage resets to 1
// (sync inactive). DEPTH = 0 degenerates to a plain wire.
module vga_sync_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctrl;
      assign unused_ctrl = clk ^ reset;
      assign dout = din;
    end else begin : g_shift
      logic [DEPTH-1:0][WIDTH-1:0] stage_q;
      logic [DEPTH-1:0][WIDTH-1:0] stage_d;

      always_comb begin
        stage_d    = stage_q;
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          stage_q <= '1;
        end else begin
          stage_q <= stage_d;
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: 10-bit pixel/line counters, registered visibility and
// start pulses, delayed active-low syncs. Optional frame counter under VGA_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int SYNC_DELAY = DEF_SYNC_DELAY
) (
  input  logic         vga_clk,
  input  logic         reset,
  output coord_t       DrawX,
  output coord_t       DrawY,
  output logic         blank,
  output logic         hs,
  output logic         vs,
  output logic         line_start,
  output logic         frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]  frame_cnt
`endif
);

  localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_VISIBLE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  generate
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL ||
        SYNC_DELAY < 0 || SYNC_DELAY > MAX_SYNC_DELAY) begin : g_bad_cfg
      $error("vga_timing_gen: totals must fit 10-bit counters and SYNC_DELAY must be 0..4");
    end
  endgenerate

  coord_t        hc_q, hc_d;
  coord_t        vc_q, vc_d;
  raster_flags_t flags_q, flags_d;
  logic          frame_wrap;
  logic [1:0]    sync_out;

  always_comb begin
    hc_d       = hc_q + coord_t'(1);
    vc_d       = vc_q;
    frame_wrap = 1'b0;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      if (vc_q == V_LAST) begin
        vc_d       = '0;
        frame_wrap = 1'b1;
      end else begin
        vc_d = vc_q + coord_t'(1);
      end
    end
  end

  // Decode from the next counter values so the registered flags match the registered coordinates.
  always_comb begin
    flags_d             = FLAGS_RESET;
    flags_d.blank       = in_window(hc_d, 0, H_VISIBLE) && in_window(vc_d, 0, V_VISIBLE);
    flags_d.line_start  = (hc_d == '0);
    flags_d.frame_start = (hc_d == '0) && (vc_d == '0);
    flags_d.hs_raw      = !in_window(hc_d, H_SYNC_START, H_SYNC_END);
    flags_d.vs_raw      = !in_window(vc_d, V_SYNC_START, V_SYNC_END);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc_q    <= '0;
      vc_q    <= '0;
      flags_q <= FLAGS_RESET;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      flags_q <= flags_d;
    end
  end

  // Extra sync stages match the renderer's registered RGB latency.
  vga_sync_delay #(
    .DEPTH (SYNC_DELAY),
    .WIDTH (2)
  ) u_sync_delay (
    .clk   (vga_clk),
    .reset (reset),
    .din   ({flags_q.hs_raw, flags_q.vs_raw}),
    .dout  (sync_out)
  );

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign blank       = flags_q.blank;
  assign line_start  = flags_q.line_start;
  assign frame_start = flags_q.frame_start;
  assign hs          = sync_out[1];
  assign vs          = sync_out[0];

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_wrap) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  logic unused_frame_wrap;
  assign unused_frame_wrap = frame_wrap;
`endif

endmodule
